drac_l15_req_arbiter: RTL and testbench

//  Shares the single L1.5 request channel among the core's memory requesters:
//  I$ miss, D$ miss-read, D$ write-buffer, uncached read and uncached write.

---
 rtl/drac_pkg.sv | 17 +
 rtl/drac_rr_arbiter.sv | 31 +++
 rtl/drac_l15_req_arbiter.sv | 138 +++++++++++++
 tb/tb_drac_l15_req_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/drac_pkg.sv
// Shared types and constants for the L1.5 request arbiter.
package drac_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } l15_arb_state_e;

  localparam int L15_ARB_NPORTS   = 5;

  localparam int L15_PORT_ICACHE  = 0;
  localparam int L15_PORT_DMISS   = 1;
  localparam int L15_PORT_WBUF    = 2;
  localparam int L15_PORT_UCREAD  = 3;
  localparam int L15_PORT_UCWRITE = 4;

endpackage

// File: rtl/drac_rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, with wrap.
module drac_rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Walk ptr+1 .. ptr+N (mod N); the first hit wins.
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 1; i <= N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/drac_l15_req_arbiter.sv
// L1.5 request channel arbiter: round-robin grant, held registered output,
// per-port outstanding credit counters.
// Optional macro DRAC_L15_ARB_ICACHE_PRIO_EN gives port 0 (I$) fixed priority.
module drac_l15_req_arbiter
  import drac_pkg::*;
#(
  parameter int NPORTS    = L15_ARB_NPORTS,
  parameter int REQ_W     = 128,
  parameter int MAX_OUTST = 2,
  parameter int PID_W     = $clog2(NPORTS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NPORTS-1:0]       req_valid_i,
  output logic [NPORTS-1:0]       req_ready_o,
  input  logic [NPORTS*REQ_W-1:0] req_data_i,
  output logic                    l15_val_o,
  output logic [REQ_W-1:0]        l15_data_o,
  output logic [PID_W-1:0]        l15_pid_o,
  input  logic                    l15_ack_i,
  input  logic                    rtrn_val_i,
  input  logic [PID_W-1:0]        rtrn_pid_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int CW = $clog2(MAX_OUTST + 1);

  l15_arb_state_e    state, state_nxt;
  logic [PID_W-1:0]  ptr;
  logic [CW-1:0]     cnt [NPORTS];
  logic [NPORTS-1:0] elig, inc, dec, nz;
  logic [NPORTS-1:0] rr_gnt, gnt;
  logic [PID_W-1:0]  rr_idx, gnt_idx;
  logic              rr_any, take, upd_ptr;

  // A port may compete only while it still has a free credit.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      elig[p] = req_valid_i[p] && (cnt[p] < CW'(MAX_OUTST));
      nz[p]   = (cnt[p] != '0);
    end
  end

  drac_rr_arbiter #(.N(NPORTS), .IW(PID_W)) u_rr (
    .req (elig),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

`ifdef DRAC_L15_ARB_ICACHE_PRIO_EN
  // I$ overrides the rotation and leaves the pointer where it was.
  always_comb begin
    gnt     = rr_gnt;
    gnt_idx = rr_idx;
    upd_ptr = 1'b1;
    if (elig[L15_PORT_ICACHE]) begin
      gnt     = NPORTS'(1) << L15_PORT_ICACHE;
      gnt_idx = PID_W'(L15_PORT_ICACHE);
      upd_ptr = 1'b0;
    end
  end
`else
  assign gnt     = rr_gnt;
  assign gnt_idx = rr_idx;
  assign upd_ptr = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and accept strobe; no accept is offered while reset is held.
  always_comb begin
    state_nxt   = state;
    take        = 1'b0;
    req_ready_o = '0;
    case (state)
      IDLE: if (rr_any && !rst_i) begin
        take        = 1'b1;
        req_ready_o = gnt;
        state_nxt   = HOLD;
      end
      HOLD: if (l15_ack_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output register and RR pointer; payload is captured once and held to ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      l15_val_o  <= 1'b0;
      l15_data_o <= '0;
      l15_pid_o  <= '0;
      ptr        <= PID_W'(NPORTS - 1);
    end else if (take) begin
      l15_val_o  <= 1'b1;
      l15_data_o <= req_data_i[int'(gnt_idx)*REQ_W +: REQ_W];
      l15_pid_o  <= gnt_idx;
      if (upd_ptr) ptr <= gnt_idx;
    end else if (state == HOLD && l15_ack_i) begin
      l15_val_o  <= 1'b0;
    end
  end

  // Credit events; a return only counts against a port that has one outstanding.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      inc[p] = take && gnt[p];
      dec[p] = rtrn_val_i && ({1'b0, rtrn_pid_i} == (PID_W+1)'(p)) && nz[p];
    end
  end

  // Per-port outstanding counters; simultaneous grant and return cancel.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < NPORTS; p++) cnt[p] <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (inc[p] && !dec[p])      cnt[p] <= cnt[p] + CW'(1);
        else if (dec[p] && !inc[p]) cnt[p] <= cnt[p] - CW'(1);
      end
    end
  end

  // Sticky error: any return that matched no counted transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                    err_o <= 1'b0;
    else if (rtrn_val_i && !(|dec)) err_o <= 1'b1;
  end

  assign busy_o = l15_val_o || (|nz);

endmodule

// File: tb/tb_drac_l15_req_arbiter.sv
// Directed bench for drac_l15_req_arbiter (default parameters).
module tb_drac_l15_req_arbiter;

  localparam int NP = 5;
  localparam int RW = 128;
  localparam int PW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    req_valid;
  logic [NP-1:0]    req_ready;
  logic [NP*RW-1:0] req_data;
  logic             l15_val;
  logic [RW-1:0]    l15_data;
  logic [PW-1:0]    l15_pid;
  logic             l15_ack;
  logic             rtrn_val;
  logic [PW-1:0]    rtrn_pid;
  logic             busy;
  logic             err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  drac_l15_req_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data_i  (req_data),
    .l15_val_o   (l15_val),
    .l15_data_o  (l15_data),
    .l15_pid_o   (l15_pid),
    .l15_ack_i   (l15_ack),
    .rtrn_val_i  (rtrn_val),
    .rtrn_pid_i  (rtrn_pid),
    .busy_o      (busy),
    .err_o       (err)
  );

  function automatic logic [RW-1:0] pay(input int p);
    return {4{32'hCAFE_0000 + 32'(p)}};
  endfunction

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int exp6 [6];

  initial begin
`ifdef DRAC_L15_ARB_ICACHE_PRIO_EN
    exp6 = '{0, 0, 1, 2, 1, 2};
`else
    exp6 = '{0, 1, 2, 0, 1, 2};
`endif
    rst = 1'b1; req_valid = '1; l15_ack = 1'b0; rtrn_val = 1'b0; rtrn_pid = '0;
    for (int p = 0; p < NP; p++) req_data[p*RW +: RW] = pay(p);

    // 1: reset with all valids high
    step(); step();
    chk("t1_rst_val",   l15_val,   0);
    chk("t1_rst_ready", req_ready, 0);
    chk("t1_rst_busy",  busy,      0);
    chk("t1_rst_err",   err,       0);
    chk("t1_rst_data",  l15_data,  0);
    rst = 1'b0; settle();
    chk("t1_first_ready", req_ready, 5'b00001);
    step();
    chk("t1_val",  l15_val, 1);
    chk("t1_pid",  l15_pid, 0);
    chk("t1_data", l15_data, pay(0));
    chk("t1_hold_ready", req_ready, 0);
    req_valid = '0; l15_ack = 1'b1; step();
    chk("t1_ack_val", l15_val, 0);
    l15_ack = 1'b0; rtrn_val = 1'b1; rtrn_pid = 3'd0; step();
    rtrn_val = 1'b0; settle();
    chk("t1_idle_busy", busy, 0);

    // 2: ports 1 and 3 alternate, returns immediate
    req_valid = 5'b01010;
    for (int k = 0; k < 4; k++) begin
      int e;
      e = (k % 2 == 0) ? 1 : 3;
      settle();
      chk($sformatf("t2_ready_%0d", k), req_ready, NP'(1) << e);
      step();
      chk($sformatf("t2_pid_%0d", k), l15_pid, e);
      chk($sformatf("t2_data_%0d", k), l15_data, pay(e));
      if (k == 0) begin
        req_data[1*RW +: RW] = 128'hDEAD_BEEF;
        step();
        chk("t2_stable_val",  l15_val, 1);
        chk("t2_stable_data", l15_data, pay(1));
        chk("t2_stable_ready", req_ready, 0);
        req_data[1*RW +: RW] = pay(1);
      end
      l15_ack = 1'b1; rtrn_val = 1'b1; rtrn_pid = PW'(e); step();
      l15_ack = 1'b0; rtrn_val = 1'b0;
    end
    req_valid = '0; settle();
    chk("t2_idle_busy", busy, 0);

    // 3: credit limit on port 2
    req_valid = 5'b00100; settle();
    chk("t3_grant1", req_ready, 5'b00100);
    step(); l15_ack = 1'b1; step(); l15_ack = 1'b0; settle();
    chk("t3_grant2", req_ready, 5'b00100);
    step(); l15_ack = 1'b1; step(); l15_ack = 1'b0; settle();
    chk("t3_full", req_ready, 0);
    chk("t3_busy", busy, 1);
    step();
    chk("t3_full_still", req_ready, 0);
    rtrn_val = 1'b1; rtrn_pid = 3'd2; settle();
    chk("t3_ret_cycle", req_ready, 0);
    step(); rtrn_val = 1'b0; settle();
    chk("t3_grant3", req_ready, 5'b00100);
    step(); l15_ack = 1'b1; step(); l15_ack = 1'b0;
    req_valid = '0; rtrn_val = 1'b1; rtrn_pid = 3'd2; step(); step();
    rtrn_val = 1'b0; settle();
    chk("t3_drained", busy, 0);
    chk("t3_no_err", err, 0);

    // 4: grant and return same cycle on port 4, then error on port 0
    req_valid = 5'b10000; settle();
    chk("t4_grant1", req_ready, 5'b10000);
    step(); l15_ack = 1'b1; step(); l15_ack = 1'b0;
    rtrn_val = 1'b1; rtrn_pid = 3'd4; settle();
    chk("t4_grant2", req_ready, 5'b10000);
    step();
    rtrn_val = 1'b0; req_valid = '0; l15_ack = 1'b1; settle();
    chk("t4_err_clear", err, 0);
    step(); l15_ack = 1'b0;
    rtrn_val = 1'b1; rtrn_pid = 3'd4; step(); rtrn_val = 1'b0; settle();
    chk("t4_ret_ok", err, 0);
    chk("t4_cnt_one", busy, 0);
    rtrn_val = 1'b1; rtrn_pid = 3'd0; step(); rtrn_val = 1'b0; settle();
    chk("t4_err_set", err, 1);
    step();
    chk("t4_err_sticky", err, 1);

    // 5: reset during HOLD with ack withheld
    req_valid = 5'b00001; step();
    chk("t5_hold_val", l15_val, 1);
    chk("t5_hold_busy", busy, 1);
    rst = 1'b1; settle();
    chk("t5_rst_val",  l15_val, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_err",  err, 0);
    chk("t5_rst_ready", req_ready, 0);
    req_valid = '0; step(); rst = 1'b0;
    rtrn_val = 1'b1; rtrn_pid = 3'd6; step(); rtrn_val = 1'b0; settle();
    chk("t5_bad_pid_err", err, 1);
    chk("t5_bad_pid_busy", busy, 0);

    // 6: ports 0,1,2 valid, no returns
    req_valid = 5'b00111;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk($sformatf("t6_ready_%0d", k), req_ready, NP'(1) << exp6[k]);
      step();
      chk($sformatf("t6_pid_%0d", k), l15_pid, exp6[k]);
      l15_ack = 1'b1; step(); l15_ack = 1'b0;
    end
    settle();
    chk("t6_all_full", req_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
